// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   state_e      : arbiter FSM encodings
//   pMode_*      : line-control mode selects
//   idx_w()      : index width for an N-entry requester set
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO_W  = 8;

  typedef enum logic [1:0] {
    sIdle    = 2'd0,
    sLock    = 2'd1,
    sRelease = 2'd2
  } state_e;

  localparam logic [1:0] pMode_NoHS   = 2'd0;
  localparam logic [1:0] pMode_RTSCTS = 2'd1;
  localparam logic [1:0] pMode_RS485  = 2'd2;

  // Width of an index into n requesters (never below one bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin select: first set bit of req at or above ptr,
// wrapping from NREQ-1 back to 0.
//   req       : request vector
//   ptr       : highest-priority index this round
//   gnt_oh_c  : one-hot winner (0 when req is 0)
//   gnt_idx_c : winner index (0 when req is 0)
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh_c,
  output logic [IW-1:0]   gnt_idx_c
);

  // One spare bit so ptr + k never overflows before the wrap subtract
  localparam int unsigned SW = IW + 1;

  logic          found;
  logic [SW-1:0] slot;

  // Scan NREQ slots starting at ptr; the first hit wins
  always_comb begin
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    found     = 1'b0;
    slot      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr} + SW'(k);
      if (slot >= SW'(NREQ)) begin
        slot = slot - SW'(NREQ);
      end
      if (!found && req[slot[IW-1:0]]) begin
        found                  = 1'b1;
        gnt_oh_c[slot[IW-1:0]] = 1'b1;
        gnt_idx_c              = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmit state machine among NREQ byte-stream requesters.
// Round-robin arbitration with packet lock; the owner keeps the transmitter
// until it flags Last or leaves Req low for TMO consecutive cycles.
//   Clk, Rst_N         : clock, async active-low reset
//   Req/Last/Data      : per-requester byte valid, end-of-packet, byte lanes
//   Ack                : one-cycle accept pulse to the owner
//   Grant              : one-hot owner, 0 when unlocked
//   THR/TF_EF/TF_RE    : single-byte holding register toward the transmit SM
//   TxIdle/TxStart/TxStop : transmit SM state decodes
//   Mode, RTSo, DE     : line-control select and registered RTS/DE outputs
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 255
) (
  input  logic                   Clk,
  input  logic                   Rst_N,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ-1:0]        Last,
  input  logic [DATA_W*NREQ-1:0] Data,
  output logic [NREQ-1:0]        Ack,
  output logic [NREQ-1:0]        Grant,
  output logic [DATA_W-1:0]      THR,
  output logic                   TF_EF,
  input  logic                   TF_RE,
  input  logic                   TxIdle,
  input  logic                   TxStart,
  input  logic                   TxStop,
  input  logic [1:0]             Mode,
  output logic                   RTSo,
  output logic                   DE
);

  localparam int unsigned      IW       = idx_w(NREQ);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic              empty_q, empty_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              rts_q, rts_d;
  logic              de_q, de_d;

  logic [NREQ-1:0]   pick_oh_c;
  logic [IW-1:0]     pick_idx_c;
  logic              load_ok_c;
  logic              line_busy_c;
  logic              tx_phase_unused;
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign data_arr[i] = Data[DATA_W*i +: DATA_W];
  end

  uart_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req       (Req),
    .ptr       (ptr_q),
    .gnt_oh_c  (pick_oh_c),
    .gnt_idx_c (pick_idx_c)
  );

  // A read in the same cycle frees the register, so a load may overlap it
  assign load_ok_c   = empty_q | TF_RE;
  // Start and stop phases are already non-idle; ~TxIdle covers the whole frame
  assign line_busy_c     = ~TxIdle;
  assign tx_phase_unused = TxStart | TxStop;

  // Next-state, holding register, timeout and line control
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ack_d   = '0;
    thr_d   = thr_q;
    empty_d = empty_q;
    tmo_d   = tmo_q;
    rts_d   = 1'b0;
    de_d    = 1'b0;

    if (TF_RE) begin
      empty_d = 1'b1;
    end

    case (state_q)
      sIdle: begin
        if (|Req) begin
          owner_d = pick_idx_c;
          grant_d = pick_oh_c;
          tmo_d   = '0;
          state_d = sLock;
        end
      end
      sLock: begin
        if (Req[owner_q]) begin
          tmo_d = '0;
          if (load_ok_c) begin
            thr_d   = data_arr[owner_q];
            empty_d = 1'b0;
            ack_d   = grant_q;
            if (Last[owner_q]) begin
              state_d = sRelease;
            end
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) begin
            state_d = sRelease;
          end
        end
      end
      sRelease: begin
        grant_d = '0;
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        state_d = sIdle;
      end
      default: begin
        state_d = sIdle;
      end
    endcase

    case (Mode)
      pMode_NoHS: begin
        rts_d = 1'b0;
        de_d  = 1'b0;
      end
      pMode_RTSCTS: rts_d = line_busy_c;
      pMode_RS485:  de_d  = line_busy_c;
      default: begin
        rts_d = 1'b0;
        de_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= sIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      thr_q   <= '0;
      empty_q <= 1'b1;
      tmo_q   <= '0;
      rts_q   <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      thr_q   <= thr_d;
      empty_q <= empty_d;
      tmo_q   <= tmo_d;
      rts_q   <= rts_d;
      de_q    <= de_d;
    end
  end

  assign Ack   = ack_q;
  assign Grant = grant_q;
  assign THR   = thr_q;
  assign TF_EF = empty_q;
  assign RTSo  = rts_q;
  assign DE    = de_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 4;

  logic        Clk;
  logic        Rst_N;
  logic [3:0]  Req;
  logic [3:0]  Last;
  logic [31:0] Data;
  logic [3:0]  Ack;
  logic [3:0]  Grant;
  logic [7:0]  THR;
  logic        TF_EF;
  logic        TF_RE;
  logic        TxIdle;
  logic        TxStart;
  logic        TxStop;
  logic [1:0]  Mode;
  logic        RTSo;
  logic        DE;

  int checks = 0;
  int errors = 0;
  int n_acks = 0;

  uart_tx_arb #(
    .NREQ (NREQ),
    .TMO  (TMO)
  ) dut (
    .Clk     (Clk),
    .Rst_N   (Rst_N),
    .Req     (Req),
    .Last    (Last),
    .Data    (Data),
    .Ack     (Ack),
    .Grant   (Grant),
    .THR     (THR),
    .TF_EF   (TF_EF),
    .TF_RE   (TF_RE),
    .TxIdle  (TxIdle),
    .TxStart (TxStart),
    .TxStop  (TxStop),
    .Mode    (Mode),
    .RTSo    (RTSo),
    .DE      (DE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner is an integer (-1 = nobody); a closing owner still shows in Grant
  // for one cycle, then the pointer moves past it.
  int         m_owner;
  bit         m_closing;
  int         m_ptr;
  int         m_quiet;
  logic [7:0] m_thr;
  bit         m_valid;
  logic [3:0] m_ack;
  bit         m_rts;
  bit         m_de;
  bit         m_room;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((r >> ((p + k) % NREQ)) & 4'd1) != 4'd0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  always @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      m_owner = -1; m_closing = 0; m_ptr = 0; m_quiet = 0;
      m_thr = 8'h00; m_valid = 0; m_ack = 4'b0; m_rts = 0; m_de = 0;
    end else begin
      m_room = !m_valid || TF_RE;
      m_ack  = 4'b0;
      m_rts  = (Mode == 2'd1) && !TxIdle;
      m_de   = (Mode == 2'd2) && !TxIdle;
      if (TF_RE) m_valid = 0;
      if (m_owner < 0) begin
        if (Req != 4'b0) begin
          m_owner = first_from(Req, m_ptr);
          m_quiet = 0;
        end
      end else if (m_closing) begin
        m_ptr     = (m_owner + 1) % NREQ;
        m_owner   = -1;
        m_closing = 0;
      end else if (bit_of(Req, m_owner)) begin
        m_quiet = 0;
        if (m_room) begin
          m_thr   = 8'(Data >> (8 * m_owner));
          m_valid = 1;
          m_ack   = 4'(1 << m_owner);
          if (bit_of(Last, m_owner)) m_closing = 1;
        end
      end else begin
        m_quiet++;
        if (m_quiet == TMO) m_closing = 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    if (Rst_N) begin
      chk("model_grant", 32'(Grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      chk("model_ack",   32'(Ack),   32'(m_ack));
      chk("model_thr",   32'(THR),   32'(m_thr));
      chk("model_tf_ef", 32'(TF_EF), 32'(!m_valid));
      chk("model_rts",   32'(RTSo),  32'(m_rts));
      chk("model_de",    32'(DE),    32'(m_de));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic set_req(input logic [1:0] i, input logic r, input logic l, input logic [7:0] d);
    Req[i] = r;
    Last[i] = l;
    Data[{i, 3'b000} +: 8] = d;
  endtask

  task automatic line_test(input logic [1:0] md);
    logic er, ed;
    er = (md == 2'd1);
    ed = (md == 2'd2);
    Mode = md; TxIdle = 1'b1; TxStart = 1'b0; TxStop = 1'b0;
    cyc();
    chk("line_pre_rts", 32'(RTSo), 32'd0);
    chk("line_pre_de", 32'(DE), 32'd0);
    TxIdle = 1'b0; TxStart = 1'b1;
    cyc();
    chk("line_start_rts", 32'(RTSo), 32'(er));
    chk("line_start_de", 32'(DE), 32'(ed));
    TxStart = 1'b0;
    cyc();
    chk("line_data_rts", 32'(RTSo), 32'(er));
    chk("line_data_de", 32'(DE), 32'(ed));
    TxStop = 1'b1;
    cyc();
    chk("line_stop_rts", 32'(RTSo), 32'(er));
    chk("line_stop_de", 32'(DE), 32'(ed));
    TxStop = 1'b0; TxIdle = 1'b1;
    cyc();
    chk("line_idle_rts", 32'(RTSo), 32'd0);
    chk("line_idle_de", 32'(DE), 32'd0);
    Mode = 2'd0;
  endtask

  initial begin
    logic got;
    int   owner, ph;
    logic [3:0] eg;

    Rst_N = 1'b0; Req = '0; Last = '0; Data = '0; TF_RE = 1'b0;
    TxIdle = 1'b1; TxStart = 1'b0; TxStop = 1'b0; Mode = 2'd0;
    repeat (3) cyc();
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_thr", 32'(THR), 32'd0);
    chk("rst_tf_ef", 32'(TF_EF), 32'd1);
    chk("rst_rts", 32'(RTSo), 32'd0);
    chk("rst_de", 32'(DE), 32'd0);

    // Requester 1 sends A5, 3C(last); requester 2 waits its turn
    Rst_N = 1'b1;
    set_req(2'd1, 1'b1, 1'b0, 8'hA5);
    set_req(2'd2, 1'b1, 1'b0, 8'h77);
    cyc();
    chk("t1_grant", 32'(Grant), 32'h2);
    chk("t1_noack", 32'(Ack), 32'h0);
    cyc();
    chk("t1_thr_a5", 32'(THR), 32'hA5);
    chk("t1_ack1", 32'(Ack), 32'h2);
    chk("t1_tf_ef", 32'(TF_EF), 32'd0);
    set_req(2'd1, 1'b1, 1'b1, 8'h3C); TF_RE = 1'b1;
    cyc();
    chk("t1_thr_3c", 32'(THR), 32'h3C);
    chk("t1_ack2", 32'(Ack), 32'h2);
    chk("t1_tf_ef2", 32'(TF_EF), 32'd0);
    set_req(2'd1, 1'b0, 1'b0, 8'h00); TF_RE = 1'b1;
    cyc();
    chk("t1_released", 32'(Grant), 32'h0);
    chk("t1_drained", 32'(TF_EF), 32'd1);
    TF_RE = 1'b0;
    cyc();
    chk("t1_next_owner", 32'(Grant), 32'h4);

    // Owner 2 sends one byte then goes silent; release after TMO low cycles
    cyc();
    chk("t3_ack", 32'(Ack), 32'h4);
    chk("t3_thr", 32'(THR), 32'h77);
    set_req(2'd2, 1'b0, 1'b0, 8'h00);
    for (int t = 0; t < TMO; t++) begin
      cyc();
      chk("t3_hold", 32'(Grant), 32'h4);
    end
    cyc();
    chk("t3_timeout", 32'(Grant), 32'h0);
    chk("t3_pending", 32'(TF_EF), 32'd0);
    chk("t3_pending_thr", 32'(THR), 32'h77);
    TF_RE = 1'b1;
    cyc();
    chk("t3_consumed", 32'(TF_EF), 32'd1);
    TF_RE = 1'b0;

    // Load coinciding with a read: register stays full, single Ack
    set_req(2'd3, 1'b1, 1'b0, 8'h11);
    cyc();
    chk("t4_grant", 32'(Grant), 32'h8);
    cyc();
    chk("t4_first", 32'(THR), 32'h11);
    set_req(2'd3, 1'b1, 1'b1, 8'h55); TF_RE = 1'b1;
    cyc();
    chk("t4_tf_ef", 32'(TF_EF), 32'd0);
    chk("t4_thr", 32'(THR), 32'h55);
    chk("t4_ack", 32'(Ack), 32'h8);
    set_req(2'd3, 1'b0, 1'b0, 8'h00); TF_RE = 1'b0;
    cyc();
    chk("t4_single_ack", 32'(Ack), 32'h0);
    chk("t4_grant_off", 32'(Grant), 32'h0);
    TF_RE = 1'b1;
    cyc();

    // All four request single-byte packets: rotation 0,1,2,3,0
    Req = 4'hF; Last = 4'hF; Data = $urandom;
    TF_RE = !TF_EF;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      owner = ((k - 1) / 3) % NREQ;
      ph    = (k - 1) % 3;
      eg    = 4'(1 << owner);
      chk("rr_grant", 32'(Grant), (ph != 2) ? 32'(eg) : 32'd0);
      chk("rr_ack", 32'(Ack), (ph == 1) ? 32'(eg) : 32'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (Ack[2'(i)]) set_req(2'(i), 1'b1, 1'b1, 8'($urandom));
      end
      TF_RE = !TF_EF;
    end
    Req = '0; Last = '0;

    // Line control timing
    line_test(2'd2);
    line_test(2'd1);

    // Reset while locked with a held byte
    Mode = 2'd1; TxIdle = 1'b0; TF_RE = 1'b0;
    set_req(2'd0, 1'b1, 1'b0, 8'h9A);
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      cyc();
      got = Ack[0];
    end
    chk("t6_setup_ack", 32'(got), 32'd1);
    chk("t6_pre_grant", 32'(Grant), 32'h1);
    chk("t6_pre_tf_ef", 32'(TF_EF), 32'd0);
    chk("t6_pre_rts", 32'(RTSo), 32'd1);
    #2 Rst_N = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(Grant), 32'h0);
    chk("t6_rst_tf_ef", 32'(TF_EF), 32'd1);
    chk("t6_rst_rts", 32'(RTSo), 32'd0);
    chk("t6_rst_de", 32'(DE), 32'd0);
    chk("t6_rst_ack", 32'(Ack), 32'h0);
    cyc();
    Rst_N = 1'b1; Mode = 2'd0; TxIdle = 1'b1;
    set_req(2'd0, 1'b1, 1'b0, 8'h21);
    set_req(2'd3, 1'b1, 1'b0, 8'h43);
    cyc();
    chk("t6_ptr_restart", 32'(Grant), 32'h1);
    Req = '0; Last = '0;

    // Randomized traffic, one mid-run reset
    for (int it = 0; it < 4000; it++) begin
      cyc();
      if (|Ack) n_acks++;
      if (it == 2000) begin
        #2 Rst_N = 1'b0;
        cyc();
        Rst_N = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        logic [1:0] ii;
        ii = 2'(i);
        if (Ack[ii]) begin
          if ($urandom_range(7) == 0) set_req(ii, 1'b0, 1'b0, 8'h00);
          else set_req(ii, 1'b1, ($urandom_range(3) == 0), 8'($urandom));
        end else if (!Req[ii]) begin
          if ($urandom_range(3) == 0) set_req(ii, 1'b1, ($urandom_range(3) == 0), 8'($urandom));
        end else if ($urandom_range(40) == 0) begin
          set_req(ii, 1'b0, 1'b0, 8'h00);
        end
      end
      TF_RE = !TF_EF && ($urandom_range(2) != 0);
      if ($urandom_range(15) == 0) TxIdle = !TxIdle;
      TxStart = !TxIdle && ($urandom_range(3) == 0);
      TxStop  = !TxIdle && !TxStart && ($urandom_range(3) == 0);
      if ($urandom_range(63) == 0) Mode = 2'($urandom_range(3));
    end
    chk("rand_ack_activity", 32'(n_acks > 100), 32'd1);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
